sum_accum: RTL and testbench
============================

Name: sum_accum

Overview:
- Downstream consumer of the 3-stage pipelined 8-bit adder (pipe_add); the adder has no valid, no stall, fixed latency.
- Receives a source-side valid alongside the adder's operands and delays it internally to align with the 9-bit sum.
- Accumulates N aligned sums into a batch total and average.
- Presents each batch result on a valid/ready output handshake, flagging overrun when the consumer stalls too long.

Parameters:
- DATA_W, 9, width of incoming sum (adder output width).
- N, 4, samples per batch; power of two, N >= 2.
- LAT, 3, adder latency in cycles; delay applied to src_valid.
- ACC_W, DATA_W+$clog2(N), derived; accumulator/result width (11 at defaults).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- src_valid  in  1  high in the cycle a/b are presented to the adder.
- sum  in  DATA_W  adder output, meaningful when delayed valid is high.
- clr  in  1  synchronous clear of in-progress batch.
- res_sum  out  ACC_W  batch total.
- res_avg  out  DATA_W  res_sum >> log2(N).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- overrun  out  1  sticky: a completed batch was discarded.
- batch_cnt  out  $clog2(N)  samples accumulated in current batch.

Behaviour:
- Reset (async, rst=1): delay line, acc, batch_cnt, res_sum, res_avg, res_valid, overrun all 0. Reset mid-batch discards partial batch and any pending result.
- Valid alignment: LAT-deep shift register on src_valid gives vld_d. vld_d is high exactly LAT cycles after src_valid, in the same cycle the matching sum appears.
- Accumulate, on vld_d:
  - If batch_cnt==0, acc <= sum (zero-extended); else acc <= acc + sum.
  - batch_cnt increments.
  - Width ACC_W guarantees no overflow; max 510*N.
- Batch complete: vld_d with batch_cnt==N-1.
  - Computes total = acc + sum; batch_cnt <= 0 (wraps).
  - acc is reloaded on the next sample.
- Output slot is a 2-state FSM, EMPTY (res_valid=0) / FULL (res_valid=1):
  - EMPTY + complete → load res_sum=total, res_avg=total>>log2(N), go FULL.
  - FULL + res_ready, no complete → EMPTY; res_sum/res_avg hold last value.
  - FULL + res_ready + complete, same cycle → load new result, stay FULL.
  - FULL + !res_ready + complete → new total discarded; overrun <= 1; res_sum/res_avg unchanged.
- Result latency: res_valid rises LAT+N cycles after the first src_valid of a batch, given back-to-back src_valid.
- Gaps in src_valid are allowed; batch spans them.
- clr (synchronous):
  - Zeroes acc, batch_cnt, overrun and the delay line, so samples in flight are dropped.
  - Does not affect res_valid, res_sum or res_avg.
  - clr and vld_d in the same cycle: clr wins, sample dropped.
- No combinational path from res_ready to any output.

Decomposition:
- Shared package: DATA_W, default N, LAT (kept equal to the adder's pipeline depth), and an enum for the EMPTY/FULL output state.
- One sub-module is natural: valid_delay. It is a parameterised LAT-deep 1-bit shift register with async reset and sync clear, reusable for other fixed-latency stages.

Test Plan:
- Basic batch: N=4, drive adder with (10,20),(30,40),(50,60),(70,80) and src_valid on 4 consecutive cycles, res_ready=1. Expect sums 30,70,110,150, then res_sum=360, res_avg=90, res_valid high 1 cycle, 7 cycles after the first src_valid.
- Max values: 4 samples of (255,255) → res_sum=2040, res_avg=510, no overflow. Then 4 samples of (0,1) → res_sum=4, res_avg=1, proving acc reloads on the new batch.
- Backpressure/overrun: res_ready=0, feed 8 samples of (1,1).
  - First batch: res_sum=8, res_valid=1.
  - Second completion: overrun=1, res_sum still 8.
  - Raise res_ready: res_valid drops next cycle.
  - clr: overrun=0.
- Simultaneous accept+complete: hold a FULL result (res_sum=8), assert res_ready in the exact completion cycle of the next batch of (2,2)×4. Expect res_sum=16, res_valid stays 1, overrun stays 0.
- Gaps and clr:
  - Samples (5,5) with src_valid on cycles 0,3,4,9 → res_sum=40.
  - Separately, 2 samples then clr → batch_cnt=0; 4 new samples of (3,3) → res_sum=24.
- Async reset mid-operation: assert rst between edges after 2 samples with a FULL result pending. Expect all outputs 0 immediately without a clock edge; after release a fresh 4-sample batch gives the correct total.

Source files
------------

// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg
//   Shared constants and types for the sum accumulator slice.
//   SUM_W   : width of the sum produced by the upstream pipelined adder.
//   BATCH_N : default number of samples per batch (power of two, >= 2).
//   ADD_LAT : pipeline depth of the upstream adder. It must track the
//             adder, because the source valid is delayed by this amount.
//   slot_state_e : state of the single-entry result slot.
package sum_accum_pkg;

  localparam int SUM_W   = 9;
  localparam int BATCH_N = 4;
  localparam int ADD_LAT = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/sum_accum_valid_delay.sv
// valid_delay
//   DEPTH-deep 1-bit shift register. It is used to align a valid strobe with
//   the output of a fixed-latency pipeline that has no valid of its own.
//   Ports:
//     clk  in  clock
//     rst  in  asynchronous active-high reset, clears every stage
//     clr  in  synchronous clear, drops every strobe still in flight
//     din  in  strobe entering the pipeline
//     dout out strobe delayed by DEPTH cycles
module valid_delay
  import sum_accum_pkg::*;
#(
  parameter int DEPTH = ADD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Written per stage so that DEPTH == 1 needs no special case.
  always_comb begin
    shift_d = '0;
    if (!clr) begin
      shift_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        shift_d[i] = shift_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/sum_accum.sv
// sum_accum
//   Consumer of the pipelined adder. It receives the adder's operand-side
//   valid and delays it by LAT cycles so it lines up with the sum. It adds N
//   aligned sums into a batch total, then offers the total and the batch
//   average on a valid/ready output held in a single-entry slot.
//   Ports:
//     clk        in   clock
//     rst        in   asynchronous active-high reset
//     src_valid  in   high in the cycle the operands enter the adder
//     sum        in   adder output, used only when the delayed valid is high
//     clr        in   synchronous clear of the batch in progress and of overrun
//     res_sum    out  batch total (ACC_W bits)
//     res_avg    out  batch total >> log2(N)
//     res_valid  out  result slot holds an unconsumed result
//     res_ready  in   consumer takes the result
//     overrun    out  sticky; a completed batch was thrown away
//     batch_cnt  out  samples accumulated in the current batch
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int N      = BATCH_N,
  parameter int LAT    = ADD_LAT,
  parameter int ACC_W  = DATA_W + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  input  logic [DATA_W-1:0]    sum,
  input  logic                 clr,
  output logic [ACC_W-1:0]     res_sum,
  output logic [DATA_W-1:0]    res_avg,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] batch_cnt
);

  localparam int CNT_W = $clog2(N);

  logic vld_d;

  valid_delay #(
    .DEPTH(LAT)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .din (src_valid),
    .dout(vld_d)
  );

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  res_sum_q, res_sum_d;
  logic [DATA_W-1:0] res_avg_q, res_avg_d;
  logic              overrun_q, overrun_d;
  slot_state_e       state_q, state_d;

  logic              take;
  logic              complete;
  logic              load;
  logic [ACC_W-1:0]  sum_ext;
  logic [ACC_W-1:0]  total;

  // clr wins over a sample that arrives in the same cycle.
  assign take     = vld_d && !clr;
  assign complete = take && (cnt_q == CNT_W'(N - 1));
  assign sum_ext  = {{(ACC_W-DATA_W){1'b0}}, sum};
  assign total    = acc_q + sum_ext;

  // The slot takes a new result when it is empty or is being drained in this
  // same cycle. Otherwise the new total is dropped and overrun is flagged.
  assign load = complete && ((state_q == SLOT_EMPTY) || res_ready);

  // Accumulator and sample counter. N is a power of two, so the counter
  // returns to zero on its own after the last sample of a batch.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = (cnt_q == '0) ? sum_ext : total;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    res_sum_d = res_sum_q;
    res_avg_d = res_avg_q;
    if (load) begin
      res_sum_d = total;
      res_avg_d = total[ACC_W-1:CNT_W];
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clr) begin
      overrun_d = 1'b0;
    end else if (complete && (state_q == SLOT_FULL) && !res_ready) begin
      overrun_d = 1'b1;
    end
  end

  // Result slot FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (complete) state_d = SLOT_FULL;
      SLOT_FULL:  if (!complete && res_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Result slot FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result slot FSM: outputs. These depend on registers only, so res_ready
  // has no combinational path to any output.
  always_comb begin
    res_valid = (state_q == SLOT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      res_sum_q <= '0;
      res_avg_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_sum_q <= res_sum_d;
      res_avg_q <= res_avg_d;
      overrun_q <= overrun_d;
    end
  end

  assign res_sum   = res_sum_q;
  assign res_avg   = res_avg_q;
  assign overrun   = overrun_q;
  assign batch_cnt = cnt_q;

endmodule

// File: tb/tb_sum_accum.sv
module tb_sum_accum;

  localparam int DATA_W = 9;
  localparam int N      = 4;
  localparam int LAT    = 3;
  localparam int ACC_W  = 11;
  localparam int LOG2N  = 2;

  logic             clk;
  logic             rst;
  logic             src_valid;
  logic [DATA_W-1:0] sum;
  logic             clr;
  logic [ACC_W-1:0] res_sum;
  logic [DATA_W-1:0] res_avg;
  logic             res_valid;
  logic             res_ready;
  logic             overrun;
  logic [1:0]       batch_cnt;

  sum_accum dut (
    .clk      (clk),
    .rst      (rst),
    .src_valid(src_valid),
    .sum      (sum),
    .clr      (clr),
    .res_sum  (res_sum),
    .res_avg  (res_avg),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .overrun  (overrun),
    .batch_cnt(batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the adder feeding the DUT: a+b shows up LAT cycles later.
  int apipe [LAT];

  // Reference model: samples in flight (issue cycle + value), the open batch
  // as a list of values, and the result slot.
  typedef struct {
    int t;
    int v;
  } ent_t;
  ent_t inq[$];
  int   batch[$];
  bit   m_full;
  bit   m_ovr;
  int   m_sum;
  int   cyc = 0;

  task automatic model_reset();
    inq.delete();
    batch.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_sum  = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model,
  // then return 1 time unit after the rising edge for sampling.
  task automatic tick(input bit sv, input int a, input int b, input bit c, input bit rdy);
    ent_t e;
    bit   arrive;
    bit   comp;
    int   val;
    int   tot;
    @(negedge clk);
    src_valid = sv;
    clr       = c;
    res_ready = rdy;
    sum       = DATA_W'(apipe[LAT-1]);
    for (int i = LAT - 1; i > 0; i--) apipe[i] = apipe[i-1];
    apipe[0] = a + b;

    arrive = 1'b0;
    comp   = 1'b0;
    val    = 0;
    tot    = 0;
    if (inq.size() > 0 && inq[0].t + LAT == cyc) begin
      arrive = 1'b1;
      val    = inq[0].v;
      void'(inq.pop_front());
    end
    if (c) begin
      inq.delete();
      batch.delete();
      m_ovr = 1'b0;
    end else begin
      if (sv) begin
        e.t = cyc;
        e.v = a + b;
        inq.push_back(e);
      end
      if (arrive) begin
        batch.push_back(val);
        if (batch.size() == N) begin
          foreach (batch[i]) tot += batch[i];
          batch.delete();
          comp = 1'b1;
        end
      end
    end
    if (comp) begin
      if (!m_full || rdy) begin
        m_full = 1'b1;
        m_sum  = tot;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    src_valid = 1'b0;
    clr       = 1'b0;
    res_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    src_valid = 1'b0;
    clr       = 1'b0;
    res_ready = 1'b0;
    sum       = '0;
    for (int i = 0; i < LAT; i++) apipe[i] = 0;
    model_reset();
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_sum !== '0 || res_avg !== '0 || overrun !== 1'b0 || batch_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%0b sum=%0d avg=%0d ovr=%0b cnt=%0d want all 0",
               res_valid, res_sum, res_avg, overrun, batch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: outputs checked at zero");
  endtask

  task automatic test_basic();
    do_reset();
    tick(1, 10, 20, 0, 1);
    tick(1, 30, 40, 0, 1);
    tick(1, 50, 60, 0, 1);
    tick(1, 70, 80, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: res_valid got %0b want 0 six cycles after first src_valid", res_valid);
    end
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd360 || res_avg !== 9'd90) begin
      n_bad++;
      $display("FAIL basic_result: got valid=%0b sum=%0d avg=%0d want 1/360/90", res_valid, res_sum, res_avg);
    end
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b0 || batch_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_drain: got valid=%0b cnt=%0d want 0/0", res_valid, batch_cnt);
    end
    $display("basic: batch 30+70+110+150 -> sum=%0d avg=%0d", res_sum, res_avg);
  endtask

  task automatic test_max();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 255, 255, 0, 1);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd2040 || res_avg !== 9'd510) begin
      n_bad++;
      $display("FAIL max_values: got valid=%0b sum=%0d avg=%0d want 1/2040/510", res_valid, res_sum, res_avg);
    end
    for (int i = 0; i < N; i++) tick(1, 0, 1, 0, 1);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd4 || res_avg !== 9'd1) begin
      n_bad++;
      $display("FAIL acc_reload: got valid=%0b sum=%0d avg=%0d want 1/4/1", res_valid, res_sum, res_avg);
    end
    $display("max: 4x510 then 4x1 -> sum=%0d avg=%0d", res_sum, res_avg);
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, 1, 1, 0, 0);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd8 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_first: got valid=%0b sum=%0d ovr=%0b want 1/8/0", res_valid, res_sum, overrun);
    end
    tick(1, 1, 1, 0, 0);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd8 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_flag: got valid=%0b sum=%0d ovr=%0b want 1/8/1", res_valid, res_sum, overrun);
    end
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b0 || res_sum !== 11'd8 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_drain: got valid=%0b sum=%0d ovr=%0b want 0/8/1", res_valid, res_sum, overrun);
    end
    tick(0, 0, 0, 1, 0);
    n_cmp++;
    if (overrun !== 1'b0 || res_sum !== 11'd8) begin
      n_bad++;
      $display("FAIL overrun_clr: got ovr=%0b sum=%0d want 0/8", overrun, res_sum);
    end
    $display("overrun: stall, flag, drain, clr done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 1, 1, 0, 0);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) tick(1, 2, 2, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd8) begin
      n_bad++;
      $display("FAIL b2b_hold: got valid=%0b sum=%0d want 1/8", res_valid, res_sum);
    end
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd16 || res_avg !== 9'd4 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept_complete: got valid=%0b sum=%0d avg=%0d ovr=%0b want 1/16/4/0",
               res_valid, res_sum, res_avg, overrun);
    end
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: res_valid got %0b want 0", res_valid);
    end
    $display("back_to_back: accept and complete in same cycle -> sum=16");
  endtask

  task automatic test_gaps();
    do_reset();
    for (int t = 0; t < 13; t++) begin
      if (t == 0 || t == 3 || t == 4 || t == 9) tick(1, 5, 5, 0, 1);
      else tick(0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 1);
      if (t == 7) begin
        n_cmp++;
        if (batch_cnt !== 2'd3 || res_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL gaps_midcount: got cnt=%0d valid=%0b want 3/0", batch_cnt, res_valid);
        end
      end
    end
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd40 || res_avg !== 9'd10) begin
      n_bad++;
      $display("FAIL gaps_result: got valid=%0b sum=%0d avg=%0d want 1/40/10", res_valid, res_sum, res_avg);
    end
    $display("gaps: spaced samples -> sum=%0d", res_sum);
  endtask

  task automatic test_clr();
    do_reset();
    tick(1, 3, 3, 0, 1);
    tick(1, 3, 3, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(1, 9, 9, 0, 1);
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (batch_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL clr_before: batch_cnt got %0d want 2", batch_cnt);
    end
    tick(0, 0, 0, 1, 1);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (batch_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL clr_after: batch_cnt got %0d want 0 (in-flight sample must drop)", batch_cnt);
    end
    for (int i = 0; i < N; i++) tick(1, 3, 3, 0, 1);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== 11'd24 || res_avg !== 9'd6) begin
      n_bad++;
      $display("FAIL clr_result: got valid=%0b sum=%0d avg=%0d want 1/24/6", res_valid, res_sum, res_avg);
    end
    $display("clr: partial batch dropped, next batch sum=%0d", res_sum);
  endtask

  task automatic test_async_reset();
    int exp_tot;
    int a;
    int b;
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 1, 1, 0, 0);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 0);
    tick(1, 7, 7, 0, 0);
    tick(1, 7, 7, 0, 0);
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (res_valid !== 1'b1 || batch_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL areset_setup: got valid=%0b cnt=%0d want 1/2", res_valid, batch_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_sum !== '0 || res_avg !== '0 || overrun !== 1'b0 || batch_cnt !== '0) begin
      n_bad++;
      $display("FAIL areset_immediate: got valid=%0b sum=%0d avg=%0d ovr=%0b cnt=%0d want all 0",
               res_valid, res_sum, res_avg, overrun, batch_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_tot = 0;
    for (int i = 0; i < N; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      exp_tot += a + b;
      tick(1, a, b, 0, 1);
    end
    for (int i = 0; i < LAT; i++) tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_sum !== ACC_W'(exp_tot) || res_avg !== DATA_W'(exp_tot >> LOG2N)) begin
      n_bad++;
      $display("FAIL areset_fresh: got valid=%0b sum=%0d avg=%0d want 1/%0d/%0d",
               res_valid, res_sum, res_avg, exp_tot, exp_tot >> LOG2N);
    end
    $display("async_reset: fresh batch after reset -> sum=%0d", res_sum);
  endtask

  task automatic test_random();
    bit sv;
    bit c;
    bit rdy;
    int bad_before;
    do_reset();
    bad_before = n_bad;
    for (int t = 0; t < 400; t++) begin
      sv  = ($urandom_range(0, 99) < 65);
      c   = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 45);
      tick(sv, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), c, rdy);
      n_cmp++;
      if (res_valid !== m_full || overrun !== m_ovr || batch_cnt !== 2'(batch.size()) ||
          res_sum !== ACC_W'(m_sum) || res_avg !== DATA_W'(m_sum >> LOG2N)) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got v=%0b ovr=%0b cnt=%0d sum=%0d avg=%0d want v=%0b ovr=%0b cnt=%0d sum=%0d avg=%0d",
                 t, res_valid, overrun, batch_cnt, res_sum, res_avg,
                 m_full, m_ovr, batch.size(), m_sum, m_sum >> LOG2N);
      end
    end
    $display("random: 400 cycles against model, %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_overrun();
    test_back_to_back();
    test_gaps();
    test_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
